// File: rtl/fifo_dp_ram_ext.sv
`default_nettype none
// ============================================================================
// Module      : fifo_dp_ram_ext
// Description : Single-clock FIFO on a simple dual-port RAM with a pipelined
//               read path, fill count, sticky error flags and sync flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_dp_ram_ext #(
    parameter int FIFO_DEPTH         = 32,
    parameter int FIFO_DATA_WIDTH    = 8,
    parameter int ALMOST_FULL_DEPTH  = 3,
    parameter int ALMOST_EMPTY_DEPTH = 3,
    parameter int LATENCY            = 3,
    parameter int PTR_WIDTH          = $clog2(FIFO_DEPTH) + 1,
    parameter int CNT_WIDTH          = PTR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       write,
    input  logic                       read,
    input  logic [FIFO_DATA_WIDTH-1:0] write_data,
    output logic [FIFO_DATA_WIDTH-1:0] read_data,
    output logic                       read_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [CNT_WIDTH-1:0]       count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_addr_width = PTR_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] c_full_level = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_af_level   = CNT_WIDTH'(FIFO_DEPTH - ALMOST_FULL_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_ae_level   = CNT_WIDTH'(ALMOST_EMPTY_DEPTH);
    localparam logic [PTR_WIDTH-1:0] c_ptr_zero   = '0;

    logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [PTR_WIDTH-1:0]       r_wr_ptr;
    logic [PTR_WIDTH-1:0]       r_rd_ptr;
    logic [CNT_WIDTH-1:0]       r_count;
    logic                       r_empty;
    logic                       r_full;
    logic                       r_almost_empty;
    logic                       r_almost_full;
    logic                       r_overflow;
    logic                       r_underflow;

    logic [LATENCY-1:0]         r_pipe_vld;
    logic [FIFO_DATA_WIDTH-1:0] r_pipe_data [LATENCY];

    logic                       w_wr_accept;
    logic                       w_rd_accept;
    logic                       w_wr_en;
    logic [PTR_WIDTH-1:0]       w_wr_ptr_nxt;
    logic [PTR_WIDTH-1:0]       w_rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]       w_count_nxt;
    logic [c_addr_width-1:0]    w_wr_addr;
    logic [c_addr_width-1:0]    w_rd_addr;

    // Acceptance uses the registered flags, so outputs never depend
    // combinationally on write/read.
    always_comb begin
        w_wr_accept  = write && !r_full;
        w_rd_accept  = read && !r_empty;
        w_wr_en      = w_wr_accept && !reset && !flush;
        w_wr_addr    = r_wr_ptr[c_addr_width-1:0];
        w_rd_addr    = r_rd_ptr[c_addr_width-1:0];
        w_wr_ptr_nxt = r_wr_ptr + {c_ptr_zero[PTR_WIDTH-1:1], w_wr_accept};
        w_rd_ptr_nxt = r_rd_ptr + {c_ptr_zero[PTR_WIDTH-1:1], w_rd_accept};
        w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == c_full_level);
            r_almost_empty <= (w_count_nxt <= c_ae_level);
            r_almost_full  <= (w_count_nxt >= c_af_level);
            if (write && r_full) begin
                r_overflow <= 1'b1;
            end
            if (read && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Data stages only advance behind a valid token, so the last stage holds
    // the most recent word through idle cycles and across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_pipe_data[k] <= '0;
            end
        end else if (flush) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_accept;
            if (w_rd_accept) begin
                r_pipe_data[0] <= r_mem[w_rd_addr];
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if (r_pipe_vld[k-1]) begin
                    r_pipe_data[k] <= r_pipe_data[k-1];
                end
            end
        end
    end

    assign read_data    = r_pipe_data[LATENCY-1];
    assign read_valid   = r_pipe_vld[LATENCY-1];
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_dp_ram_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_dp_ram_ext
// Description : Self-checking bench for fifo_dp_ram_ext (vector table plus
//               directed multi-cycle sequences against a queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_dp_ram_ext;

    localparam int DEPTH = 32;
    localparam int DW    = 8;
    localparam int AFD   = 3;
    localparam int AED   = 3;
    localparam int LAT   = 3;
    localparam int CW    = 6;
    localparam int NV    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    fifo_dp_ram_ext #(
        .FIFO_DEPTH        (DEPTH),
        .FIFO_DATA_WIDTH   (DW),
        .ALMOST_FULL_DEPTH (AFD),
        .ALMOST_EMPTY_DEPTH(AED),
        .LATENCY           (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .write       (write),
        .read        (read),
        .write_data  (write_data),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic          fl;
        logic [DW-1:0] wd;
        int            cnt;
        logic          emp;
        logic          ful;
        logic          ae;
        logic          af;
        logic          ovf;
        logic          unf;
        logic          rv;
        logic [DW-1:0] rdat;
    } vec_t;

    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: stored words, sticky flags, expected
    // read_valid/read_data per cycle slot.
    logic [DW-1:0] m_q [$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_last;
    logic          ev [64];
    logic [DW-1:0] ed [64];
    int            cyc = 0;

    function automatic vec_t mk(input logic w, input logic r, input logic f, input logic [DW-1:0] wd,
                                input int c, input logic e, input logic fu, input logic ae,
                                input logic af, input logic ov, input logic un, input logic rv,
                                input logic [DW-1:0] rdat);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.wd = wd; v.cnt = c; v.emp = e; v.ful = fu;
        v.ae = ae; v.af = af; v.ovf = ov; v.unf = un; v.rv = rv; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int c;
        int idx;
        c   = m_q.size();
        idx = cyc % 64;
        if (ev[idx]) m_last = ed[idx];
        chk({tag, " count"},        32'(count),        32'(c));
        chk({tag, " empty"},        32'(empty),        32'(c == 0));
        chk({tag, " full"},         32'(full),         32'(c == DEPTH));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= AED));
        chk({tag, " almost_full"},  32'(almost_full),  32'(c >= DEPTH - AFD));
        chk({tag, " overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, " underflow"},    32'(underflow),    32'(m_unf));
        chk({tag, " read_valid"},   32'(read_valid),   32'(ev[idx]));
        chk({tag, " read_data"},    32'(read_data),    32'(m_last));
        ev[idx] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; write_data = '0;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = '0;
        for (int k = 0; k < 64; k++) ev[k] = 1'b0;
        check_model("reset");
    endtask

    task automatic cycle(input logic w, input logic r, input logic f, input logic [DW-1:0] wd,
                         input string tag);
        logic          was_full;
        logic          was_empty;
        logic [DW-1:0] d;
        write = w; read = r; flush = f; write_data = wd;
        @(posedge clk);
        cyc++;
        if (f) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            for (int k = 0; k < LAT; k++) ev[(cyc + k) % 64] = 1'b0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) begin
                d = m_q.pop_front();
                ev[(cyc + LAT - 1) % 64] = 1'b1;
                ed[(cyc + LAT - 1) % 64] = d;
            end
            if (w && !was_full) m_q.push_back(wd);
        end
        #1;
        write = 1'b0; read = 1'b0; flush = 1'b0;
        check_model(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        //              w    r    f    wd     cnt emp ful ae  af  ovf unf rv  rdata
        vecs[0]  = mk(1'b0,1'b1,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
        vecs[1]  = mk(1'b1,1'b0,1'b0,8'hA5, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
        vecs[2]  = mk(1'b1,1'b0,1'b0,8'h3C, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
        vecs[3]  = mk(1'b1,1'b1,1'b0,8'h77, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
        vecs[4]  = mk(1'b0,1'b1,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
        vecs[5]  = mk(1'b0,1'b0,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'hA5);
        vecs[6]  = mk(1'b0,1'b0,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h3C);
        vecs[7]  = mk(1'b0,1'b0,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C);
        vecs[8]  = mk(1'b1,1'b0,1'b0,8'h11, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C);
        vecs[9]  = mk(1'b1,1'b0,1'b0,8'h22, 3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C);
        vecs[10] = mk(1'b1,1'b0,1'b0,8'h33, 4, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h3C);
        vecs[11] = mk(1'b0,1'b1,1'b0,8'h00, 3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C);
        vecs[12] = mk(1'b1,1'b1,1'b1,8'h44, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h3C);
        vecs[13] = mk(1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h3C);
        vecs[14] = mk(1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h3C);
        vecs[15] = mk(1'b0,1'b1,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h3C);

        do_reset();

        for (int i = 0; i < NV; i++) begin
            write = vecs[i].wr; read = vecs[i].rd; flush = vecs[i].fl; write_data = vecs[i].wd;
            @(posedge clk);
            #1;
            write = 1'b0; read = 1'b0; flush = 1'b0;
            chk($sformatf("v%0d count", i),        32'(count),        32'(vecs[i].cnt));
            chk($sformatf("v%0d empty", i),        32'(empty),        32'(vecs[i].emp));
            chk($sformatf("v%0d full", i),         32'(full),         32'(vecs[i].ful));
            chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            chk($sformatf("v%0d almost_full", i),  32'(almost_full),  32'(vecs[i].af));
            chk($sformatf("v%0d overflow", i),     32'(overflow),     32'(vecs[i].ovf));
            chk($sformatf("v%0d underflow", i),    32'(underflow),    32'(vecs[i].unf));
            chk($sformatf("v%0d read_valid", i),   32'(read_valid),   32'(vecs[i].rv));
            chk($sformatf("v%0d read_data", i),    32'(read_data),    32'(vecs[i].rdat));
        end

        // Fill to overflow, then drain to underflow.
        do_reset();
        for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i), "fill1");
        for (int i = 0; i < 33; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "drain1");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle1");

        // Flush, offset the pointers, then fill/drain across the wrap.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, "flush1");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), "warm_wr");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "warm_rd");
        for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 1'b0, 8'(32 + i), "fill2");
        for (int i = 0; i < 33; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "drain2");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle2");

        // Streaming fill then streaming drain.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, "flush2");
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i), "stream_wr");
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "stream_rd");
        for (int i = 0; i < LAT + 1; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle3");

        // Simultaneous read/write at count 5, then at count 0.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(100 + i), "pre_rw");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 8'(105 + i), "rw5");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "post_rw");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle4");
        cycle(1'b1, 1'b1, 1'b0, 8'hEE, "rw0");
        chk("rw0 count_is_1", 32'(count), 32'd1);
        chk("rw0 underflow_set", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, "rw0_drain");
        for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle5");

        // Flush with reads still in the pipeline.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, "flush3");
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "inflight_wr");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, "inflight_rd");
        chk("inflight count_is_10", 32'(count), 32'd10);
        cycle(1'b1, 1'b1, 1'b1, 8'hFF, "flush_inflight");
        chk("flush_inflight count_is_0", 32'(count), 32'd0);
        for (int i = 0; i < LAT; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, "post_flush");
            chk("post_flush no_read_valid", 32'(read_valid), 32'd0);
        end

        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
